// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift register front end: FSM state encoding
// and the default word width used by both the serializer and the register.
package shift_pkg;

    localparam int SHIFT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

endpackage

// File: rtl/shift_serializer_if.sv
// Word handshake between a producer (master) and shift_serializer (slave).
interface shift_serializer_if
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEF
);
    logic [WIDTH-1:0] word_i;
    logic             valid_i;
    logic             msb_first_i;
    logic             ready_o;

    modport master (
        output word_i,
        output valid_i,
        output msb_first_i,
        input  ready_o
    );

    modport slave (
        input  word_i,
        input  valid_i,
        input  msb_first_i,
        output ready_o
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial front end for the shift register. Accepts one word per
// valid/ready transfer and emits it one bit per clock, MSB- or LSB-first.
// Optional feature macro: SHIFT_SERIALIZER_PARITY_EN appends an even-parity
// bit after the data bits (frame becomes WIDTH+1 cycles).
//
// state  | meaning
// IDLE   | no frame in progress, ready for a word, en_o low
// SHIFT  | emitting data bits, cnt_q indexes the bit on data_o
// PARITY | emitting the parity bit (parity build only)
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    shift_serializer_if.slave  bus,
    output logic               data_o,
    output logic               en_o,
    output logic               dir_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam logic [1:0] ST_PARITY = PARITY;
`else
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dir_q, dir_d;
    logic             data_q, data_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [WIDTH-1:0] word_in;
    logic             last;
    logic             ready;
    logic             xfer;

    assign word_in = bus.word_i;
    assign last    = (cnt_q == LAST);

    // Ready in IDLE and during the final-bit cycle so frames can stream back-to-back.
`ifdef SHIFT_SERIALIZER_PARITY_EN
    assign ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
    assign ready = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && last);
`endif
    assign xfer  = bus.valid_i && ready;

    // Next-state logic: advance the frame, then let a transfer override to load a new one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dir_d   = dir_q;
        data_d  = 1'b0;
        en_d    = 1'b0;
        done_d  = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                if (!last) begin
                    // sh_q already has the emitted bit shifted out; take the next one.
                    cnt_d  = cnt_q + 1'b1;
                    data_d = dir_q ? sh_q[WIDTH-1] : sh_q[0];
                    sh_d   = dir_q ? (sh_q << 1) : (sh_q >> 1);
                    en_d   = 1'b1;
`ifndef SHIFT_SERIALIZER_PARITY_EN
                    done_d = (cnt_q == PENULT);
`endif
                end else begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    state_d = ST_PARITY;
                    data_d  = par_q;
                    en_d    = 1'b1;
                    done_d  = 1'b1;
`else
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (xfer) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            dir_d   = bus.msb_first_i;
            data_d  = bus.msb_first_i ? word_in[WIDTH-1] : word_in[0];
            sh_d    = bus.msb_first_i ? (word_in << 1) : (word_in >> 1);
            en_d    = 1'b1;
            done_d  = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_d   = ^word_in;
`endif
        end
    end

    // Frame registers and registered serial outputs; reset discards any frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dir_q   <= 1'b0;
            data_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.ready_o = ready;
    assign data_o      = data_q;
    assign en_o        = en_q;
    assign busy_o      = en_q;
    assign dir_o       = dir_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer: the driver pushes the expected
// serial stream of each accepted word, the monitor pops one entry per cycle.
module tb_shift_serializer;

    localparam int W = 8;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic data;
        logic dir;
        logic done;
    } exp_t;

    logic clk;
    logic rstn;
    logic data_o, en_o, dir_o, busy_o, done_o;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    shift_serializer_if #(.WIDTH(W)) bus ();

    shift_serializer #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus),
        .data_o (data_o),
        .en_o   (en_o),
        .dir_o  (dir_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected serial stream of one word.
    task automatic push_frame(input logic [W-1:0] w, input logic m);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.data = m ? w[W-1-i] : w[i];
            e.dir  = m;
            e.done = (i == W - 1) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.data = ^w;
            e.dir  = m;
            e.done = 1'b1;
            q.push_back(e);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the transfer edge.
    task automatic send(input logic [W-1:0] w, input logic m);
        int  guard;
        bit  sent;
        bit  xfer;
        guard = 0;
        sent  = 1'b0;
        bus.word_i      = w;
        bus.msb_first_i = m;
        bus.valid_i     = 1'b1;
        while (!sent) begin
            @(negedge clk);
            xfer = bus.ready_o && rstn;
            @(posedge clk);
            if (xfer) begin
                push_frame(w, m);
                sent = 1'b1;
            end
            #1;
            guard++;
            if (!sent && guard > 100) begin
                chk("send_timeout", 1'b1, 1'b0);
                sent = 1'b1;
            end
        end
        bus.valid_i     = 1'b0;
        bus.word_i      = W'($urandom);
        bus.msb_first_i = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) chk("idle_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle while a frame is queued, idle otherwise.
    always @(negedge clk) begin
        exp_t e;
        chk("ready", bus.ready_o, q.size() <= 1);
        chk("busy", busy_o, q.size() != 0);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("en", en_o, 1'b1);
            chk("data", data_o, e.data);
            chk("dir", dir_o, e.dir);
            chk("done", done_o, e.done);
        end else begin
            chk("en_idle", en_o, 1'b0);
            chk("data_idle", data_o, 1'b0);
            chk("done_idle", done_o, 1'b0);
        end
    end

    initial begin
        rstn            = 1'b0;
        bus.valid_i     = 1'b0;
        bus.word_i      = '0;
        bus.msb_first_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dir", dir_o, 1'b0);
        chk("rst_ready", bus.ready_o, 1'b1);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_dir", dir_o, 1'b0);

        send(8'hA5, 1'b1);
        wait_idle();
        send(8'h01, 1'b0);
        wait_idle();

        // Streaming: valid stays high across the final-bit edge.
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);
        wait_idle();

        // Reset during bit 4 of 8'hC3.
        send(8'hC3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        q.delete();
        #1;
        chk("midrst_en", en_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_data", data_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send(8'h3C, 1'b0);
        wait_idle();
        send(8'h07, 1'b1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), 1'($urandom));
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
